// File: rtl/spart_tx_fifo.sv
// Byte FIFO feeding the RS232 transmitter: host writes at any rate, one byte issued per frame
// via a registered en_tx pulse when tbr is high (write-to-en_tx latency 2 cycles); full drops writes.
module spart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_err,
  input  logic          tbr,
  output logic [7:0]    tx_data,
  output logic          en_tx,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf_err
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          en_tx_q, en_tx_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          ovf_err_q, ovf_err_d;

  logic wrote;
  logic issue;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign en_tx   = en_tx_q;
  assign tx_data = tx_data_q;
  assign ovf_err = ovf_err_q;

  // The en_tx_q term forces a gap cycle so the transmitter can drop tbr.
  assign issue = tbr && !empty && !en_tx_q && !flush;
  assign wrote = wr_en && !full && !flush;

  always_comb begin
    mem_d = mem_q;
    if (wrote) begin
      mem_d[wr_ptr_q] = wr_data;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    en_tx_d   = 1'b0;
    tx_data_d = tx_data_q;
    ovf_err_d = ovf_err_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wrote) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (issue) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        tx_data_d = mem_q[rd_ptr_q];
        en_tx_d   = 1'b1;
      end
      unique case ({wrote, issue})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end

    // A dropped write outranks a same-cycle clear.
    if (wr_en && full && !flush) begin
      ovf_err_d = 1'b1;
    end else if (clr_err) begin
      ovf_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      en_tx_q   <= 1'b0;
      tx_data_q <= 8'h00;
      ovf_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      en_tx_q   <= en_tx_d;
      tx_data_q <= tx_data_d;
      ovf_err_q <= ovf_err_d;
    end
  end

endmodule

// File: tb/tb_spart_tx_fifo.sv
// Bench for spart_tx_fifo: table vectors, hand-written corner sequences, then random traffic
// against a queue-based reference model.
module tb_spart_tx_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        clr_err;
  logic        tbr;
  logic [7:0]  tx_data;
  logic        en_tx;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        ovf_err;

  always #5 clk = ~clk;

  spart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clr_err(clr_err), .tbr(tbr), .tx_data(tx_data), .en_tx(en_tx),
    .full(full), .empty(empty), .count(count), .ovf_err(ovf_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: queue contents plus the transmitter-side registers.
  logic [7:0] mq[$];
  logic       m_en  = 1'b0;
  logic [7:0] m_tx  = 8'h00;
  logic       m_ovf = 1'b0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fl;
    logic       clr;
    logic       tb;
    logic       e_en;
    logic [7:0] e_tx;
    int         e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic wr, logic [7:0] d, logic fl, logic clr, logic tb,
                              logic e_en, logic [7:0] e_tx, int e_cnt, logic e_ovf);
    vec_t v;
    v.wr = wr; v.d = d; v.fl = fl; v.clr = clr; v.tb = tb;
    v.e_en = e_en; v.e_tx = e_tx; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit was_full;
    bit iss;
    was_full = (mq.size() == DEPTH);
    iss      = tbr && (mq.size() != 0) && !m_en && !flush;
    if (flush) begin
      mq.delete();
      m_en = 1'b0;
    end else begin
      if (iss) m_tx = mq.pop_front();
      if (wr_en && !was_full) mq.push_back(wr_data);
      m_en = iss;
    end
    if (wr_en && was_full && !flush) m_ovf = 1'b1;
    else if (clr_err) m_ovf = 1'b0;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [7:0] d, input logic fl,
                       input logic clr, input logic tb);
    wr_en = wr; wr_data = d; flush = fl; clr_err = clr; tbr = tb;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " en_tx"},   en_tx,   m_en);
    chk({tag, " tx_data"}, tx_data, m_tx);
    chk({tag, " count"},   count,   mq.size());
    chk({tag, " full"},    full,    mq.size() == DEPTH);
    chk({tag, " empty"},   empty,   mq.size() == 0);
    chk({tag, " ovf_err"}, ovf_err, m_ovf);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Write A5 then one issue; tbr drops after the pulse.
    vt.push_back(mk(1, 8'hA5, 0, 0, 1, 0, 8'h00, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'hA5, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hA5, 0, 0));
    // Fill to DEPTH, then one dropped write.
    for (int i = 1; i <= 8; i++)
      vt.push_back(mk(1, 8'(i), 0, 0, 0, 0, 8'hA5, i, 0));
    vt.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 8'hA5, 8, 1));
    // Drain with one tbr pulse per frame.
    for (int i = 1; i <= 8; i++) begin
      vt.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'(i), 8 - i, 1));
      vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'(i), 8 - i, 1));
    end
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h08, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset en_tx", en_tx, 0);
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset count", count, 0);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset ovf_err", ovf_err, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].wr, vt[i].d, vt[i].fl, vt[i].clr, vt[i].tb);
      cycle();
      chk($sformatf("vec%0d en_tx", i),   en_tx,   vt[i].e_en);
      chk($sformatf("vec%0d tx_data", i), tx_data, vt[i].e_tx);
      chk($sformatf("vec%0d count", i),   count,   vt[i].e_cnt);
      chk($sformatf("vec%0d full", i),    full,    vt[i].e_cnt == DEPTH);
      chk($sformatf("vec%0d empty", i),   empty,   vt[i].e_cnt == 0);
      chk($sformatf("vec%0d ovf_err", i), ovf_err, vt[i].e_ovf);
    end

    // Full FIFO: write during issue cycle is still dropped.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("full+issue en_tx", en_tx, 1);
    chk("full+issue tx_data", tx_data, 8'h10);
    chk("full+issue count", count, 7);
    chk("full+issue ovf_err", ovf_err, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("flush count", count, 0);
    chk("flush keeps ovf_err", ovf_err, 1);

    // count=3: simultaneous write and issue keeps count.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 8'h23, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("wr+issue en_tx", en_tx, 1);
    chk("wr+issue tx_data", tx_data, 8'h20);
    chk("wr+issue count", count, 3);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle();

    // Flush wins over a same-cycle write and issue.
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    chk("pre-flush count", count, 5);
    drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("flush-prio count", count, 0);
    chk("flush-prio empty", empty, 1);
    chk("flush-prio en_tx", en_tx, 0);
    chk("flush-prio tx_data", tx_data, 8'h20);
    chk("flush-prio ovf_err", ovf_err, 1);

    // Asynchronous reset during the en_tx cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("pre-rst en_tx", en_tx, 1);
    chk("pre-rst count", count, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst en_tx", en_tx, 0);
    chk("async rst count", count, 0);
    chk("async rst ovf_err", ovf_err, 0);
    chk("async rst empty", empty, 1);
    mq.delete();
    m_en = 1'b0; m_tx = 8'h00; m_ovf = 1'b0;
    #3;
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("post-rst idle%0d en_tx", i), en_tx, 0);
      chk($sformatf("post-rst idle%0d count", i), count, 0);
    end

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 40);
      cycle();
      chk_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
